dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Sequential data-memory responder: the target side of the pipeline's memory-stage data interface.
- The pipeline issues one read or write request; this block accepts it through a valid/ready handshake, models a fixed access latency, and performs a little-endian 8-byte access to a byte array.
- It returns read data, or a completion, plus an address-error flag through a valid/ready response channel.
- Only one transaction is outstanding at a time.

Parameters:
- DEPTH, 1024, memory size in bytes; must be >= 8.
- LATENCY, 2, clock edges from request acceptance to rsp_valid rising; must be >= 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  64  byte address of the access; unaligned addresses are legal.
- req_wdata  in  64  write data, little-endian.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  64  read data; 0 for writes and errored accesses.
- rsp_error  out  1  address error (maps to SADR upstream).
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- Reset:
  - Clock is named clock; reset is reset_n, asynchronous, active-low.
  - Reset forces state IDLE and clears counter, latched request, rsp_rdata, rsp_error and rsp_valid to 0.
  - req_ready = 1 once reset_n is high.
  - Memory array contents are not affected by reset.
- States: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE). rsp_valid = (state == RESP). busy = (state != IDLE).
- IDLE:
  - On an edge with req_valid & req_ready, latch req_write, req_addr and req_wdata.
  - Load cnt = LATENCY-1 and go to WAIT.
  - req_* inputs are ignored at all other times.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access on this edge and go to RESP.
  - rsp_valid therefore rises LATENCY edges after the acceptance edge.
- Access, as one edge-atomic operation:
  - err = (addr > DEPTH-8), as an unsigned 64-bit compare. No wrap-around; an address near 2^64 is an error.
  - Read, no error: rsp_rdata = {mem[a+7], ..., mem[a]}.
  - Write, no error: mem[a+i] = wdata[8i+7:8i] for i = 0..7; rsp_rdata = 0.
  - Error: no array byte changes; rsp_rdata = 0; rsp_error = 1.
- RESP:
  - rsp_rdata and rsp_error hold stable while rsp_valid = 1 and rsp_ready = 0.
  - On an edge with rsp_ready = 1, go to IDLE.
  - rsp_rdata and rsp_error keep their values until the next access edge.
- Throughput: with rsp_ready held at 1, back-to-back requests are accepted every LATENCY+2 cycles.
- Simultaneous events:
  - req_valid during WAIT or RESP is not accepted; the requester must hold it.
  - rsp_ready while not in RESP has no effect.
- Reset mid-operation:
  - Asserted in WAIT: the access is abandoned and memory is unchanged.
  - Asserted in RESP: the write has already committed; the response is dropped.
- Counter width is clog2(LATENCY)+1 bits. Address arithmetic a+i uses a clog2(DEPTH)-bit index, evaluated only when err = 0.

Test Plan:
- Write then read, LATENCY = 2, rsp_ready = 1.
  - Stimulus: write addr 0x10, data 0x1122334455667788; then read 0x10.
  - Response: rsp_valid rises 2 edges after each acceptance; the write returns rdata 0 and error 0; the read returns 0x1122334455667788 and error 0.
- Unaligned little-endian overlap.
  - Stimulus: write 0x00 = 0x0807060504030201; write 0x04 = 0xFFEEDDCCBBAA9988; read 0x02.
  - Response: rdata 0xDDCCBBAA99880403.
- Boundary errors, DEPTH = 1024.
  - Read 0x3F8: error 0.
  - Write 0x3F9 with 0xDEAD: error 1, rdata 0; a following read of 0x3F8 is unchanged.
  - Read 0xFFFFFFFFFFFFFFFC: error 1.
- Response backpressure.
  - Stimulus: hold rsp_ready = 0 for 5 cycles after rsp_valid rises, with req_valid held high for a second request.
  - Response: rsp_rdata and rsp_error stable; req_ready = 0 throughout; the second request is accepted the cycle after rsp_ready pulses.
- Reset mid-WAIT, LATENCY = 4.
  - Stimulus: accept a write to 0x20 = 0xAA, then pulse reset_n low 2 cycles later.
  - Response: immediately rsp_valid = 0, busy = 0, req_ready = 1 after release; a read of 0x20 returns the prior contents.
- Throughput.
  - Stimulus: 4 back-to-back reads with rsp_ready = 1, LATENCY = 1.
  - Response: acceptances exactly 3 cycles apart; 4 responses in order.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits a fixed latency,
// then performs a little-endian 8-byte access and returns a response.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [63:0] LAST = 64'(DEPTH - 8);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lat_write;
  logic [63:0]   lat_addr;
  logic [63:0]   lat_wdata;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic          err;
  logic          accept;
  logic          access;
  logic [63:0]   rd_word;

  assign idx = lat_addr[AW-1:0];
  // unsigned compare: no wrap, so addresses near 2^64 are errors
  assign err = lat_addr > LAST;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (access) begin
        rsp_error <= err;
        rsp_rdata <= (err || lat_write) ? '0 : rd_word;
      end
    end
  end

  // array is not reset; access is low whenever reset holds state in IDLE
  always_ff @(posedge clock) begin
    if (access && lat_write && !err) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= lat_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) checked
// against a byte-array reference model, vector table and corner sequences.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic [2:0]  reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_write;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [2:0]  rsp_error;
  logic [2:0]  busy;
  logic [63:0] req_addr  [3];
  logic [63:0] req_wdata [3];
  logic [63:0] rsp_rdata [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  mdl [3][DEPTH];
  logic [63:0] rq [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 4 : 1))
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_error(rsp_error[g]),
      .busy     (busy[g])
    );
  end

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rsp_valid[2] && rsp_ready[2]) rq.push_back(rsp_rdata[2]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // reference: a flat byte array, little-endian, bounds-checked
  task automatic model(input int k, input bit w, input logic [63:0] a,
                       input logic [63:0] d, output logic [63:0] r,
                       output bit e);
    int base;
    e = (a > 64'(DEPTH - 8));
    r = '0;
    base = int'(a[31:0]);
    if (!e) begin
      for (int i = 0; i < 8; i++) begin
        if (w) mdl[k][base + i] = d[8*i +: 8];
        else   r[8*i +: 8] = mdl[k][base + i];
      end
    end
  endtask

  task automatic txn(input int k, input bit w, input logic [63:0] a,
                     input logic [63:0] d, output logic [63:0] rd,
                     output bit er, output int lat);
    int n;
    int acc;
    @(negedge clock);
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    rsp_ready[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_ready", 64'(req_ready[k]), 64'd1);
    @(posedge clock);
    #1;
    acc = cyc;
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid[k]), 64'd1);
    lat = cyc - acc;
    rd  = rsp_rdata[k];
    er  = rsp_error[k];
    @(posedge clock);
    #1;
  endtask

  task automatic run_chk(input int k, input bit w, input logic [63:0] a,
                         input logic [63:0] d, input string tag);
    logic [63:0] rd, er_exp_r;
    bit er, er_exp;
    int lat;
    txn(k, w, a, d, rd, er, lat);
    model(k, w, a, d, er_exp_r, er_exp);
    chk({tag, "_rdata"}, rd, er_exp_r);
    chk({tag, "_error"}, 64'(er), 64'(er_exp));
    chk({tag, "_latency"}, 64'(lat), 64'(lat_of(k)));
  endtask

  typedef struct {
    bit          w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] er;
    bit          ee;
  } vec_t;

  initial begin
    vec_t        tbl [10];
    logic [63:0] rd, mr, a, a1, a2, e1, e2;
    logic [63:0] ta [4];
    logic [63:0] te [4];
    int          acc [4];
    bit          er, me;
    int          lat, n, sel;

    tbl[0] = '{1'b1, 64'h10, 64'h1122334455667788, 64'h0, 1'b0};
    tbl[1] = '{1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0};
    tbl[2] = '{1'b1, 64'h00, 64'h0807060504030201, 64'h0, 1'b0};
    tbl[3] = '{1'b1, 64'h04, 64'hFFEEDDCCBBAA9988, 64'h0, 1'b0};
    tbl[4] = '{1'b0, 64'h02, 64'h0, 64'hDDCCBBAA99880403, 1'b0};
    tbl[5] = '{1'b1, 64'h3F8, 64'h0123456789ABCDEF, 64'h0, 1'b0};
    tbl[6] = '{1'b0, 64'h3F8, 64'h0, 64'h0123456789ABCDEF, 1'b0};
    tbl[7] = '{1'b1, 64'h3F9, 64'hDEAD, 64'h0, 1'b1};
    tbl[8] = '{1'b0, 64'h3F8, 64'h0, 64'h0123456789ABCDEF, 1'b0};
    tbl[9] = '{1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1};

    reset_n   = '0;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rsp_valid", 64'(rsp_valid[k]), 64'd0);
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_rdata", rsp_rdata[k], 64'd0);
      chk("rst_error", 64'(rsp_error[k]), 64'd0);
    end
    @(negedge clock);
    reset_n = '1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 64'(req_ready[k]), 64'd1);
    end

    for (int i = 0; i < DEPTH / 8; i++) begin
      run_chk(0, 1'b1, 64'(i * 8), {$urandom, $urandom}, "prefill");
    end

    for (int i = 0; i < 10; i++) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].d, rd, er, lat);
      model(0, tbl[i].w, tbl[i].a, tbl[i].d, mr, me);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("vec%0d_error", i), 64'(er), 64'(tbl[i].ee));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
    end

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else if (sel == 1) a = 64'(DEPTH - 12 + $urandom_range(0, 12));
      else               a = 64'($urandom_range(0, DEPTH - 8));
      run_chk(0, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, "rand");
    end

    // backpressure: response held, second request pending meanwhile
    a1 = 64'h40;
    a2 = 64'h123;
    model(0, 1'b0, a1, 64'h0, e1, me);
    model(0, 1'b0, a2, 64'h0, e2, me);
    @(negedge clock);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = a1;
    rsp_ready[0] = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    req_addr[0] = a2;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("bp_first_valid", 64'(rsp_valid[0]), 64'd1);
    chk("bp_first_rdata", rsp_rdata[0], e1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_hold_valid", 64'(rsp_valid[0]), 64'd1);
      chk("bp_hold_rdata", rsp_rdata[0], e1);
      chk("bp_hold_error", 64'(rsp_error[0]), 64'd0);
      chk("bp_hold_ready", 64'(req_ready[0]), 64'd0);
    end
    @(negedge clock);
    rsp_ready[0] = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready[0] = 1'b0;
    chk("bp_idle_ready", 64'(req_ready[0]), 64'd1);
    chk("bp_idle_busy", 64'(busy[0]), 64'd0);
    @(posedge clock);
    #1;
    chk("bp_second_accept", 64'(busy[0]), 64'd1);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("bp_second_valid", 64'(rsp_valid[0]), 64'd1);
    chk("bp_second_rdata", rsp_rdata[0], e2);
    @(posedge clock);
    #1;

    // reset while the write is still waiting: memory must be untouched
    run_chk(1, 1'b1, 64'h20, 64'h5A5A_0F0F_C3C3_9696, "rw_pre");
    @(negedge clock);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 64'h20;
    req_wdata[1] = 64'hAA;
    rsp_ready[1] = 1'b1;
    n = 0;
    while (!req_ready[1] && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rw_in_wait", 64'(busy[1]), 64'd1);
    reset_n[1] = 1'b0;
    #1;
    chk("rw_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    chk("rw_busy", 64'(busy[1]), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n[1] = 1'b1;
    #1;
    chk("rw_req_ready", 64'(req_ready[1]), 64'd1);
    run_chk(1, 1'b0, 64'h20, 64'h0, "rw_post");

    // throughput at LATENCY 1: one acceptance every 3 cycles
    ta[0] = 64'h000;
    ta[1] = 64'h105;
    ta[2] = 64'h20B;
    ta[3] = 64'h3F8;
    for (int j = 0; j < 4; j++) begin
      run_chk(2, 1'b1, ta[j], {$urandom, $urandom}, "tp_fill");
      model(2, 1'b0, ta[j], 64'h0, te[j], me);
    end
    rq.delete();
    @(negedge clock);
    rsp_ready[2] = 1'b1;
    req_write[2] = 1'b0;
    req_valid[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      req_addr[2] = ta[j];
      n = 0;
      while (!req_ready[2] && n < 50) begin
        @(negedge clock);
        n++;
      end
      @(posedge clock);
      #1;
      acc[j] = cyc;
    end
    req_valid[2] = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("tp_gap%0d", j), 64'(acc[j] - acc[j-1]), 64'd3);
    end
    chk("tp_count", 64'(rq.size()), 64'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < rq.size()) chk($sformatf("tp_rdata%0d", j), rq[j], te[j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
